// File: rtl/wave_capture.sv
// Sample RAM writer: arms on a rising zero crossing, fills the hidden half,
// flips read_index when the display is idle. Option: CAPTURE_TIMEOUT_EN.
module wave_capture #(
    parameter int SAMPLE_W        = 16,
    parameter int DEPTH_LOG2      = 8,
    parameter int TIMEOUT_SAMPLES = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       new_sample_ready,
    input  logic signed [SAMPLE_W-1:0] new_sample_in,
    input  logic                       wave_display_idle,
    output logic [DEPTH_LOG2:0]        write_address,
    output logic                       write_enable,
    output logic [7:0]                 write_sample,
    output logic                       read_index
);

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } state_t;

    localparam logic signed [SAMPLE_W-1:0] ZERO = '0;
    localparam logic [DEPTH_LOG2-1:0] LAST = '1;

    if (SAMPLE_W < 8 || DEPTH_LOG2 < 1 || TIMEOUT_SAMPLES < 1) begin : g_bad_cfg
        $error("wave_capture: invalid parameter set");
    end

    state_t                       state_q, state_d;
    logic                         ri_q, ri_d;
    logic                         we_q, we_d;
    logic [DEPTH_LOG2:0]          addr_q, addr_d;
    logic [7:0]                   ws_q, ws_d;
    logic [DEPTH_LOG2-1:0]        cnt_q, cnt_d;
    logic signed [SAMPLE_W-1:0]   prev_q, prev_d;
    logic [7:0]                   conv;
    logic                         crossing;

    assign conv     = {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2 -: 7]};
    assign crossing = (prev_q < ZERO) && (new_sample_in >= ZERO);

`ifdef CAPTURE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_SAMPLES + 1);
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_SAMPLES);
    logic [TO_W-1:0] to_q, to_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) to_q <= '0;
        else        to_q <= to_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        ri_d    = ri_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        ws_d    = ws_q;
        cnt_d   = cnt_q;
        prev_d  = new_sample_ready ? new_sample_in : prev_q;
`ifdef CAPTURE_TIMEOUT_EN
        to_d    = to_q;
`endif
        unique case (state_q)
            ARMED: begin
                if (new_sample_ready) begin
                    if (crossing) begin
                        state_d = ACTIVE;
                        cnt_d   = '0;
`ifdef CAPTURE_TIMEOUT_EN
                        to_d    = '0;
                    end else if (to_q == TO_LIM) begin
                        // forced start: this strobe's sample lands at index 0
                        state_d = ACTIVE;
                        to_d    = '0;
                        we_d    = 1'b1;
                        addr_d  = {~ri_q, {DEPTH_LOG2{1'b0}}};
                        ws_d    = conv;
                        cnt_d   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
                    end else begin
                        to_d    = to_q + 1'b1;
`endif
                    end
                end
            end
            ACTIVE: begin
                if (new_sample_ready) begin
                    we_d   = 1'b1;
                    addr_d = {~ri_q, cnt_q};
                    ws_d   = conv;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = WAIT;
                end
            end
            WAIT: begin
                if (wave_display_idle) begin
                    ri_d    = ~ri_q;
                    state_d = ARMED;
`ifdef CAPTURE_TIMEOUT_EN
                    to_d    = '0;
`endif
                end
            end
            default: state_d = ARMED;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARMED;
            ri_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            ws_q    <= '0;
            cnt_q   <= '0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            ri_q    <= ri_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            ws_q    <= ws_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
        end
    end

    assign write_address = addr_q;
    assign write_enable  = we_q;
    assign write_sample  = ws_q;
    assign read_index    = ri_q;

endmodule
